easyaxi_slv_rd: RTL and testbench

AXI4 read-channel slave: accepts one read request on AR and returns the burst on R. It is the responder counterpart to the EasyAXI master read path inside the EasyAXI top, and closes the loop so the master's `enable`/`done` sequence runs against real handshakes. Read data is generated from the beat address, so the bench checks it without a backing memory. One outstanding transaction; the next AR is accepted only after the previous RLAST handshake.

---
 rtl/easyaxi_slv_rd_if.sv | 30 +++
 rtl/easyaxi_slv_rd.sv | 157 +++++++++++++++
 tb/tb_easyaxi_slv_rd.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/easyaxi_slv_rd_if.sv
// AXI4 read-channel (AR + R) signal bundle for the EasyAXI read slave.
interface easyaxi_slv_rd_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/easyaxi_slv_rd.sv
// AXI4 read slave: one outstanding burst, data = beat address ^ PATTERN.
// Optional range/size/burst error flagging is built in when EASYAXI_SLV_RD_ERR_EN is defined.
module easyaxi_slv_rd #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned SLV_BYTES  = 1024,
    parameter logic [31:0] PATTERN    = 32'h5A5A_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    easyaxi_slv_rd_if.slave axi
);
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || SLV_BYTES == 0) begin : g_param_check
        $error("easyaxi_slv_rd: DATA_WIDTH must be 32 or 64 and SLV_BYTES non-zero");
    end

    typedef enum logic {IDLE, BURST} state_e;
    state_e state_q, state_d;

    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wmask_q, wmask_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic                  fixed_q, fixed_d, wrap_q, wrap_d, err_q, err_d;

    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  ar_hs, r_hs, wrap_ok, ar_err;
    logic [31:0]           span;
    logic [ADDR_WIDTH-1:0] addr_inc, addr_nxt;

    assign ar_hs = axi.arvalid && arready_q && (state_q == IDLE);
    assign r_hs  = rvalid_q && axi.rready;

    // WRAP is honoured only for legal lengths and a size-aligned start; otherwise INCR.
    assign span    = (32'(axi.arlen) + 32'd1) << axi.arsize;
    assign wrap_ok = (axi.arlen == 8'd1 || axi.arlen == 8'd3 || axi.arlen == 8'd7 || axi.arlen == 8'd15)
                  && ((32'(axi.araddr) & ((32'd1 << axi.arsize) - 32'd1)) == 32'd0);

`ifdef EASYAXI_SLV_RD_ERR_EN
    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
    logic [32:0] last_byte;

    always_comb begin
        if (axi.arburst == 2'b00)
            last_byte = 33'(axi.araddr);
        else if (axi.arburst == 2'b10 && wrap_ok)
            last_byte = 33'(axi.araddr) | 33'(span - 32'd1);
        else
            last_byte = 33'(axi.araddr) + 33'(span) - 33'd1;
        ar_err = (33'(axi.araddr) >= 33'(SLV_BYTES)) || (last_byte >= 33'(SLV_BYTES))
              || (axi.arburst == 2'b11) || (32'(axi.arsize) > MAX_SIZE);
    end
`else
    assign ar_err = 1'b0;
`endif

    assign addr_inc = addr_q + ADDR_WIDTH'(32'd1 << size_q);
    assign addr_nxt = fixed_q ? addr_q
                    : wrap_q  ? ((addr_q & ~wmask_q) | (addr_inc & wmask_q))
                    : addr_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            wmask_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            fixed_q   <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            fixed_q   <= fixed_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (ar_hs) state_d = BURST;
            BURST: if (r_hs && rlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d    = id_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        fixed_d = fixed_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        if (ar_hs) begin
            id_d    = axi.arid;
            addr_d  = axi.araddr;
            wmask_d = ADDR_WIDTH'(span - 32'd1);
            len_d   = axi.arlen;
            cnt_d   = '0;
            size_d  = axi.arsize;
            fixed_d = (axi.arburst == 2'b00);
            wrap_d  = (axi.arburst == 2'b10) && wrap_ok;
            err_d   = ar_err;
        end else if (r_hs && !rlast_q) begin
            addr_d = addr_nxt;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // R outputs are registered from the next beat state; the first BURST cycle is the load slot.
    always_comb begin
        arready_d = (state_d == IDLE);
        rvalid_d  = (state_q == BURST) && (state_d == BURST);
        rid_d     = rvalid_d ? id_d : '0;
        rdata_d   = (rvalid_d && !err_d) ? (DATA_WIDTH'(addr_d) ^ DATA_WIDTH'(PATTERN)) : '0;
        rlast_d   = rvalid_d && (cnt_d == len_d);
        rresp_d   = (rvalid_d && err_d) ? 2'b10 : 2'b00;
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed bench for easyaxi_slv_rd: hand-computed beat addresses checked with immediate assertions.
module tb_easyaxi_slv_rd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_addr [16];
    logic        exp_err;

    always #5 clk = ~clk;

    easyaxi_slv_rd_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    easyaxi_slv_rd #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .ID_WIDTH(4),
        .SLV_BYTES(1024),
        .PATTERN(32'h5A5A_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
        chk({tag, "_rid"},    64'(bus.rid),    64'd0);
        chk({tag, "_rdata"},  64'(bus.rdata),  64'd0);
        chk({tag, "_rresp"},  64'(bus.rresp),  64'd0);
        chk({tag, "_rlast"},  64'(bus.rlast),  64'd0);
    endtask

    // rready held high; beat addresses come from exp_addr[], error flag from exp_err.
    task automatic run_burst(input string tag, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        chk({tag, "_arready_idle"}, 64'(bus.arready), 64'd1);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arid    = id;
        bus.rready  = 1'b1;
        step();
        bus.arvalid = 1'b0;
        chk({tag, "_arready_busy"}, 64'(bus.arready), 64'd0);
        chk({tag, "_load_rvalid"},  64'(bus.rvalid),  64'd0);
        step();
        for (int i = 0; i <= int'(len); i++) begin
            chk($sformatf("%s_rvalid%0d", tag, i), 64'(bus.rvalid), 64'd1);
            chk($sformatf("%s_rdata%0d", tag, i), 64'(bus.rdata),
                exp_err ? 64'd0 : {32'd0, 16'h5A5A, exp_addr[i]});
            chk($sformatf("%s_rid%0d", tag, i),   64'(bus.rid),   64'(id));
            chk($sformatf("%s_rlast%0d", tag, i), 64'(bus.rlast), (i == int'(len)) ? 64'd1 : 64'd0);
            chk($sformatf("%s_rresp%0d", tag, i), 64'(bus.rresp), exp_err ? 64'd2 : 64'd0);
            step();
        end
        chk({tag, "_end_rvalid"},  64'(bus.rvalid),  64'd0);
        chk({tag, "_end_arready"}, 64'(bus.arready), 64'd1);
    endtask

    initial begin
        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.rready  = 1'b0;
        exp_err     = 1'b0;

        step();
        step();
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk_idle_outputs("rst");
        rst_n = 1'b1;
        step();
        chk("post_rst_arready", 64'(bus.arready), 64'd1);

        // Single beat
        exp_addr[0] = 16'h0010;
        run_burst("single", 16'h0010, 8'd0, 3'd2, 2'b01, 4'd3);

        // INCR with rready toggling: outputs must hold during low cycles
        bus.arvalid = 1'b1;
        bus.araddr  = 16'h0100;
        bus.arlen   = 8'd3;
        bus.arsize  = 3'd2;
        bus.arburst = 2'b01;
        bus.arid    = 4'd5;
        bus.rready  = 1'b0;
        step();
        bus.arvalid = 1'b0;
        step();
        exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0104;
        exp_addr[2] = 16'h0108; exp_addr[3] = 16'h010C;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_rdata%0d", i), 64'(bus.rdata), {32'd0, 16'h5A5A, exp_addr[i]});
            chk($sformatf("bp_rlast%0d", i), 64'(bus.rlast), (i == 3) ? 64'd1 : 64'd0);
            bus.rready = 1'b0;
            step();
            chk($sformatf("bp_hold_rvalid%0d", i), 64'(bus.rvalid), 64'd1);
            chk($sformatf("bp_hold_rdata%0d", i),  64'(bus.rdata), {32'd0, 16'h5A5A, exp_addr[i]});
            chk($sformatf("bp_hold_rid%0d", i),    64'(bus.rid), 64'd5);
            chk($sformatf("bp_hold_rlast%0d", i),  64'(bus.rlast), (i == 3) ? 64'd1 : 64'd0);
            bus.rready = 1'b1;
            step();
        end
        chk("bp_end_rvalid",  64'(bus.rvalid),  64'd0);
        chk("bp_end_arready", 64'(bus.arready), 64'd1);

        // WRAP over a 16-byte block
        exp_addr[0] = 16'h0038; exp_addr[1] = 16'h003C;
        exp_addr[2] = 16'h0030; exp_addr[3] = 16'h0034;
        run_burst("wrap", 16'h0038, 8'd3, 3'd2, 2'b10, 4'd7);

        // WRAP with illegal length behaves as INCR
        exp_addr[0] = 16'h0038; exp_addr[1] = 16'h003C; exp_addr[2] = 16'h0040;
        run_burst("wrap_len2", 16'h0038, 8'd2, 3'd2, 2'b10, 4'd1);

        // FIXED keeps the address
        exp_addr[0] = 16'h0020; exp_addr[1] = 16'h0020;
        run_burst("fixed", 16'h0020, 8'd1, 3'd2, 2'b00, 4'd2);

        // INCR wraps at 2^ADDR_WIDTH
`ifdef EASYAXI_SLV_RD_ERR_EN
        exp_err = 1'b1;
`endif
        exp_addr[0] = 16'hFFFC; exp_addr[1] = 16'h0000;
        run_burst("addr_wrap", 16'hFFFC, 8'd1, 3'd2, 2'b01, 4'd6);

        // Reserved burst type behaves as INCR
        exp_addr[0] = 16'h0200; exp_addr[1] = 16'h0204;
        run_burst("rsvd", 16'h0200, 8'd1, 3'd2, 2'b11, 4'd4);

        // Burst crossing the end of the decoded window
        exp_addr[0] = 16'h03F8; exp_addr[1] = 16'h03FC;
        exp_addr[2] = 16'h0400; exp_addr[3] = 16'h0404;
        run_burst("range", 16'h03F8, 8'd3, 3'd2, 2'b01, 4'd8);
        exp_err = 1'b0;

        // 16-beat burst, back-to-back
        for (int i = 0; i < 16; i++) exp_addr[i] = 16'h0000 + 16'(4 * i);
        run_burst("len16", 16'h0000, 8'd15, 3'd2, 2'b01, 4'd15);

        // Reset during beat 2 of an 8-beat burst
        bus.arvalid = 1'b1;
        bus.araddr  = 16'h0080;
        bus.arlen   = 8'd7;
        bus.arsize  = 3'd2;
        bus.arburst = 2'b01;
        bus.arid    = 4'd9;
        bus.rready  = 1'b1;
        step();
        bus.arvalid = 1'b0;
        step();
        step();
        step();
        chk("mid_beat2_rdata", 64'(bus.rdata), 64'h5A5A_0088);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arready", 64'(bus.arready), 64'd0);
        chk_idle_outputs("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rel_arready", 64'(bus.arready), 64'd1);
        chk("mid_rel_rvalid",  64'(bus.rvalid),  64'd0);
        exp_addr[0] = 16'h0044;
        run_burst("after_rst", 16'h0044, 8'd0, 3'd2, 2'b01, 4'd10);
        step();
        chk("final_rvalid", 64'(bus.rvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
